psx_action_decoder: RTL



---
 rtl/psx_action_decoder.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/psx_action_decoder.sv
// Debounces PSX jump/duck/start channels into held levels and queues press/release events.
// Latency: input change -> *_held at edge D+1, event visible after edge D+2; ev_ready backpressure holds pending flags.
module psx_action_decoder #(
  parameter logic [15:0] DEBOUNCE_CYCLES   = 16'd2000,
  parameter logic [7:0]  STICK_LOW_THRESH  = 8'h40,
  parameter logic [7:0]  STICK_HIGH_THRESH = 8'hC0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] button_state,
  input  logic [31:0] stick_state,
  output logic        jump_held,
  output logic        duck_held,
  output logic        ev_valid,
  output logic [1:0]  ev_code,
  input  logic        ev_ready,
  output logic        overflow
);

  localparam logic [1:0] EV_JUMP_PRESS  = 2'b00;
  localparam logic [1:0] EV_DUCK_ON     = 2'b01;
  localparam logic [1:0] EV_DUCK_OFF    = 2'b10;
  localparam logic [1:0] EV_START_PRESS = 2'b11;

  logic [15:0] b_q;
  logic [31:0] s_q;
  logic [7:0]  ly;

  // Channel index: 0 jump, 1 duck, 2 start.
  logic [2:0]  raw;
  logic [2:0]  db;
  logic [2:0]  flip;
  logic [15:0] cnt [3];

  // Pending flags indexed by event code.
  logic [3:0]  pend;
  logic [3:0]  set_vec;
  logic [3:0]  push_sel;
  logic [1:0]  push_code;
  logic        push;
  logic        pop;
  logic        can_push;

  logic [1:0]  mem [4];
  logic [1:0]  wr_ptr;
  logic [1:0]  rd_ptr;
  logic [2:0]  count;

  assign ly     = s_q[7:0];
  assign raw[0] = ~b_q[11] | ~b_q[1] | (ly < STICK_LOW_THRESH);
  assign raw[1] = ~b_q[9] | (ly > STICK_HIGH_THRESH);
  assign raw[2] = ~b_q[12];

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      flip[i] = (raw[i] != db[i]) && (cnt[i] == DEBOUNCE_CYCLES - 16'd1);
    end
  end

  assign set_vec[EV_JUMP_PRESS]  = flip[0] & raw[0];
  assign set_vec[EV_DUCK_ON]     = flip[1] & raw[1];
  assign set_vec[EV_DUCK_OFF]    = flip[1] & ~raw[1];
  assign set_vec[EV_START_PRESS] = flip[2] & raw[2];

  assign ev_valid = (count != 3'd0);
  assign ev_code  = mem[rd_ptr];
  assign pop      = ev_valid & ev_ready;
  assign can_push = (count != 3'd4) | pop;

  always_comb begin
    push_sel  = 4'b0000;
    push_code = EV_JUMP_PRESS;
    if (can_push) begin
      if (pend[EV_START_PRESS]) begin
        push_sel[EV_START_PRESS] = 1'b1;
        push_code                = EV_START_PRESS;
      end else if (pend[EV_JUMP_PRESS]) begin
        push_sel[EV_JUMP_PRESS]  = 1'b1;
        push_code                = EV_JUMP_PRESS;
      end else if (pend[EV_DUCK_ON]) begin
        push_sel[EV_DUCK_ON]     = 1'b1;
        push_code                = EV_DUCK_ON;
      end else if (pend[EV_DUCK_OFF]) begin
        push_sel[EV_DUCK_OFF]    = 1'b1;
        push_code                = EV_DUCK_OFF;
      end
    end
  end

  assign push = |push_sel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // Idle input values so reset release cannot look like a press.
      b_q <= 16'hFFFF;
      s_q <= 32'h8080_8080;
      db  <= 3'b000;
      for (int i = 0; i < 3; i++) cnt[i] <= 16'd0;
    end else begin
      b_q <= button_state;
      s_q <= stick_state;
      for (int i = 0; i < 3; i++) begin
        if (raw[i] == db[i]) begin
          cnt[i] <= 16'd0;
        end else if (flip[i]) begin
          db[i]  <= raw[i];
          cnt[i] <= 16'd0;
        end else begin
          cnt[i] <= cnt[i] + 16'd1;
        end
      end
    end
  end

  // A new edge landing on a flag that survives this cycle's push is a merge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend     <= 4'b0000;
      overflow <= 1'b0;
    end else begin
      pend <= (pend & ~push_sel) | set_vec;
      if (|(set_vec & pend & ~push_sel)) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) mem[i] <= 2'b00;
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 3'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_code;
        wr_ptr      <= wr_ptr + 2'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  assign jump_held = db[0];
  assign duck_held = db[1];

endmodule
